priority_encoder_8to3: RTL and testbench

Registered 8-to-3 priority encoder: reports the index of the highest set bit of an 8-bit request vector, gated by an enable. It serves as the request-selection stage in front of arbitration and interrupt-style logic, where one winning index must be chosen from several simultaneous requests. Outputs are registered and update one clock after the inputs are sampled.

---
 rtl/priority_encoder_8to3.sv | 107 ++++++++++
 tb/tb_priority_encoder_8to3.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/priority_encoder_8to3.sv
// priority_encoder_8to3
//
// Registered priority encoder. Reports the index of the highest set bit of
// the request vector, gated by an enable. All outputs are registered. They
// update one clock after in/en are sampled.
//
// Parameters:
//   WIDTH  request vector width (power of two, >= 2)
//   OUT_W  index width, derived as $clog2(WIDTH)
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset, clears all outputs immediately
//   in     request vector, bit WIDTH-1 has highest priority
//   en     encoder enable; low forces 0/0/0 at the next edge
//   y      index of the highest-priority active request (qualify with valid)
//   valid  en was high and at least one request was set
//   multi  valid and two or more requests were set
module priority_encoder_8to3 #(
  parameter  int WIDTH = 8,
  localparam int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi
);

  // One-hot "this bit wins" vector.
  // A bit wins when it is set and no higher bit is set.
  logic [WIDTH-1:0] win;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_win
      if (gi == WIDTH - 1) begin : g_top
        assign win[gi] = in[gi];
      end else begin : g_low
        assign win[gi] = in[gi] & ~(|in[WIDTH-1:gi+1]);
      end
    end
  endgenerate

  logic [OUT_W-1:0] idx_next;
  logic             any_next;
  logic             cnt2_next;

  // Convert the one-hot winner to a binary index.
  // At most one bit of win is set, so OR-ing the indices is exact.
  always_comb begin
    idx_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (win[i]) begin
        idx_next = idx_next | OUT_W'(i);
      end
    end
  end

  assign any_next = |in;

  // Two-or-more detector.
  // seen_one tracks whether any lower bit was set. A set bit seen while
  // seen_one is already high means at least two bits are set.
  always_comb begin
    logic seen_one;
    seen_one  = 1'b0;
    cnt2_next = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i] && seen_one) begin
        cnt2_next = 1'b1;
      end
      if (in[i]) begin
        seen_one = 1'b1;
      end
    end
  end

  logic [OUT_W-1:0] y_reg;
  logic             valid_reg;
  logic             multi_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg     <= '0;
      valid_reg <= 1'b0;
      multi_reg <= 1'b0;
    end else if (en && any_next) begin
      y_reg     <= idx_next;
      valid_reg <= 1'b1;
      multi_reg <= cnt2_next;
    end else begin
      // Disabled or no request: report nothing.
      // Do not hold the last winner.
      y_reg     <= '0;
      valid_reg <= 1'b0;
      multi_reg <= 1'b0;
    end
  end

  assign y     = y_reg;
  assign valid = valid_reg;
  assign multi = multi_reg;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench for priority_encoder_8to3.
// Outputs are compared as the packed value {y, valid, multi}.
module tb_priority_encoder_8to3;

  logic       clk;
  logic       rst;
  logic [7:0] in_s;
  logic       en_s;
  logic [2:0] y;
  logic       valid;
  logic       multi;

  int checks = 0;
  int errors = 0;

  priority_encoder_8to3 dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_s),
    .en    (en_s),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[%0t] FAIL %s: actual=%h required=%h", $time, tag, obs, exp);
    end else begin
      $display("[%0t] ok   %s: value=%h", $time, tag, obs);
    end
  endtask

  function automatic logic [7:0] pack(input logic [2:0] yy, input logic vv, input logic mm);
    return {3'b000, yy, vv, mm};
  endfunction

  function automatic logic [7:0] observed();
    return {3'b000, y, valid, multi};
  endfunction

  // Reference model: scan from the MSB down, take the first set bit,
  // and count the set bits.
  function automatic logic [7:0] model(input logic [7:0] v, input logic e);
    logic [2:0] yy;
    logic       found;
    yy    = 3'd0;
    found = 1'b0;
    if (!e || v == 8'h00) return pack(3'd0, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      if (v[i] && !found) begin
        yy    = 3'(i);
        found = 1'b1;
      end
    end
    return pack(yy, 1'b1, $countones(v) >= 2);
  endfunction

  // Flag X/Z on in while enabled.
  always @(negedge clk) begin
    if (en_s === 1'b1 && $isunknown(in_s))
      check_val("x_on_in", 8'(1), 8'(0));
  end

  // Apply inputs on the falling edge.
  // The DUT captures them on the next rising edge.
  // Outputs are checked on the falling edge after that.
  task automatic step(input string tag, input logic [7:0] v, input logic e, input logic [7:0] exp);
    in_s = v;
    en_s = e;
    @(posedge clk);
    @(negedge clk);
    check_val(tag, observed(), exp);
  endtask

  initial begin
    rst  = 1'b0;
    in_s = 8'hFF;
    en_s = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("pre_reset_ff", observed(), pack(3'd7, 1'b1, 1'b1));

    // Async reset between edges: outputs must clear without a clock edge.
    #1 rst = 1'b1;
    #1 check_val("async_rst_clear", observed(), pack(3'd0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check_val("rst_held", observed(), pack(3'd0, 1'b0, 1'b0));
    rst = 1'b0;

    // Enable gating: in=FF with en=0 must report nothing.
    for (int k = 0; k < 3; k++)
      step("en0_ff", 8'hFF, 1'b0, pack(3'd0, 1'b0, 1'b0));

    step("single_low",  8'b0000_0001, 1'b1, pack(3'd0, 1'b1, 1'b0));
    step("multi_0f",    8'b0000_1111, 1'b1, pack(3'd3, 1'b1, 1'b1));
    step("zero_en1",    8'h00,        1'b1, pack(3'd0, 1'b0, 1'b0));
    step("top_only",    8'h80,        1'b1, pack(3'd7, 1'b1, 1'b0));
    step("all_ones",    8'hFF,        1'b1, pack(3'd7, 1'b1, 1'b1));
    step("mid_pair",    8'b0101_0000, 1'b1, pack(3'd6, 1'b1, 1'b1));
    step("bit5_only",   8'b0010_0000, 1'b1, pack(3'd5, 1'b1, 1'b0));
    step("en_fall",     8'hFF,        1'b0, pack(3'd0, 1'b0, 1'b0));

    // Exhaustive sweep with en=1, one new value per cycle.
    for (int v = 0; v < 256; v++)
      step($sformatf("sweep_%02h", v), 8'(v), 1'b1, model(8'(v), 1'b1));

    // en toggling with in=24: outputs alternate 5/1/1 and 0/0/0.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) step("toggle_en1", 8'h24, 1'b1, pack(3'd5, 1'b1, 1'b1));
      else            step("toggle_en0", 8'h24, 1'b0, pack(3'd0, 1'b0, 1'b0));
    end

    // Mid-stream async reset while y=6 and valid=1.
    step("pre_pulse_y6", 8'h40, 1'b1, pack(3'd6, 1'b1, 1'b0));
    in_s = 8'h24;
    en_s = 1'b1;
    #2 rst = 1'b1;
    #1 check_val("pulse_clear", observed(), pack(3'd0, 1'b0, 1'b0));
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("post_pulse_24", observed(), pack(3'd5, 1'b1, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
